exc_sequencer: RTL and testbench
================================

// Module: exc_sequencer
// PURPOSE
//  Exception/interrupt sequencer for the single-cycle LEGv8 datapath with exception support.
//  Captures exception sources (invalid opcode, external IRQs) into a pending register and picks one by priority.
//  Drives Exc/EStatus to the controller, waits for ExcAck (PC == vector 0xD8), holds the cause until ERET.
//  No nesting: new events during a handler stay pending.
// PARAMETERS
//  NIRQ         4   number of external IRQ lines, 1..13, so every cause code fits EStatus[3:0]
//  ACK_TIMEOUT  16  cycles in REQ before the watchdog aborts; used only when EXC_ACK_TIMEOUT_EN is defined
// PORTS
//  clk          in   1     clock, all state updates on rising edge
//  reset        in   1     asynchronous, active-low reset
//  invalid_op   in   1     1-cycle pulse from decode: unimplemented opcode
//  irq          in   NIRQ  1-cycle pulse per external interrupt line
//  irq_mask     in   NIRQ  1 = line masked; a masked pulse is dropped, never captured
//  eret         in   1     ERET instruction executing (from controller)
//  exc_ack      in   1     datapath ExcAck: fetch PC equals exception vector
//  exc          out  1     exception request to controller (Exc)
//  estatus      out  4     cause code (EStatus); 0 = none
//  busy         out  1     state != IDLE
//  pending      out  NIRQ+1  pending vector {irq[NIRQ-1:0], invalid_op}
//  eret_err     out  1     1-cycle pulse: eret seen outside HANDLER
//  ack_timeout  out  1     1-cycle pulse: watchdog abort (tied 0 without the macro)
// BEHAVIOUR
//  Reset (reset==0, async): state=IDLE; pending=0; estatus=0; exc=0; eret_err=0; ack_timeout=0; counter=0.
//  Cause codes: 4'h1 = invalid opcode (highest priority); 4'h2+k = irq[k]; lower k wins.
//  Capture: pending[b] <= pending[b] | source[b]. Bit b is cleared only when it is selected.
//   A set and a clear of the same bit in the same cycle leave the bit set (the new event is kept).
//  FSM (all outputs registered):
//   IDLE: if |pending, latch estatus = code of highest-priority pending bit, clear that bit, go to REQ.
//   REQ: exc=1. If exc_ack is 1, go to HANDLER; exc drops in the following cycle.
//   HANDLER: exc=0, estatus held. If eret is 1, go to IDLE and estatus becomes 0 in the next cycle.
//  Latency: source pulse at edge t sets pending at t+1, gives REQ with exc=1 at t+2.
//   After ERET, a pending event re-enters REQ 2 cycles later (IDLE, then REQ).
//  exc_ack outside REQ is ignored.
//  eret in IDLE or REQ: ignored for state; eret_err pulses the next cycle.
//  Sources keep accumulating in every state; pending is never lost except by reset.
//  Reset mid-operation: immediate return to reset values; in-flight cause and pending are discarded.
// CONFIGURATION
//  EXC_ACK_TIMEOUT_EN defined:
//   Counter clears on REQ entry and increments each REQ cycle without exc_ack.
//   When it reaches ACK_TIMEOUT-1 without ack: go to IDLE, estatus=0, the cause is dropped (not re-pended),
//    ack_timeout pulses 1 cycle.
//   exc_ack in the same cycle as the limit: ack wins.
//  Not defined: REQ waits indefinitely, no counter logic, ack_timeout tied 0.
// STRUCTURE
//  Package exc_pkg: typedef enum logic[1:0] {IDLE, REQ, HANDLER} exc_state_t;
//   localparams ES_NONE=4'h0, ES_INVOP=4'h1, ES_IRQ_BASE=4'h2; exc vector constant 64'hD8.
//  Sub-module exc_prio_enc: combinational pending[NIRQ:0] -> {valid, onehot clear mask, code[3:0]}.
//  Top: pending reg, FSM, estatus reg, optional watchdog counter.
// TESTING
//  invalid_op pulse at cycle 3 -> pending[0]=1 @4; exc=1, estatus=1 @5; exc_ack @7 -> HANDLER, exc=0 @8.
//  irq=4'b0110 and invalid_op together -> first estatus=1; after ERET estatus=2+1=3, then after next ERET 2+2=4.
//  irq[2] pulse with irq_mask[2]=1 -> pending stays 0, exc never set.
//  eret while IDLE -> eret_err=1 for exactly 1 cycle, state stays IDLE, estatus=0.
//  irq[0] pulse during HANDLER -> pending[1]=1, no exc until ERET; exc=1 two cycles after ERET.
//  Macro on, ACK_TIMEOUT=16, exc_ack never given -> ack_timeout pulse on 16th REQ cycle, busy=0 next.
//  Reset low mid-REQ -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/exc_pkg.sv
// Shared types and constants for the LEGv8 exception sequencer.
package exc_pkg;

    typedef enum logic [1:0] {IDLE, REQ, HANDLER} exc_state_t;

    localparam int unsigned ES_W        = 4;
    localparam logic [3:0]  ES_NONE     = 4'h0;
    localparam logic [3:0]  ES_INVOP    = 4'h1;
    localparam logic [3:0]  ES_IRQ_BASE = 4'h2;
    localparam logic [63:0] EXC_VECTOR  = 64'hD8;

    // Cause code for pending bit b: bit 0 is invalid opcode, bit k+1 is irq[k].
    function automatic logic [3:0] cause_code(input int unsigned bit_idx);
        return (bit_idx == 0) ? ES_INVOP : ES_IRQ_BASE + 4'(bit_idx - 1);
    endfunction

endpackage

// File: rtl/exc_sequencer_if.sv
// Source/controller handshake bundle of the exception sequencer.
interface exc_sequencer_if #(
    parameter int unsigned NIRQ = 4
);
    logic            invalid_op;
    logic [NIRQ-1:0] irq;
    logic [NIRQ-1:0] irq_mask;
    logic            eret;
    logic            exc_ack;
    logic            exc;
    logic [3:0]      estatus;
    logic            busy;
    logic [NIRQ:0]   pending;
    logic            eret_err;
    logic            ack_timeout;

    modport master (
        output invalid_op, irq, irq_mask, eret, exc_ack,
        input  exc, estatus, busy, pending, eret_err, ack_timeout
    );

    modport slave (
        input  invalid_op, irq, irq_mask, eret, exc_ack,
        output exc, estatus, busy, pending, eret_err, ack_timeout
    );
endinterface

// File: rtl/exc_prio_enc.sv
// Fixed-priority pick of one pending cause; lowest bit index wins.
module exc_prio_enc
    import exc_pkg::*;
#(
    parameter int unsigned NIRQ = 4
) (
    input  logic [NIRQ:0] req,
    output logic          valid_c,
    output logic [NIRQ:0] clr_c,
    output logic [3:0]    code_c
);

    // Scan high to low so the lowest set bit is the last one written.
    always_comb begin
        valid_c = |req;
        clr_c   = '0;
        code_c  = ES_NONE;
        for (int i = int'(NIRQ); i >= 0; i--) begin
            if (req[i]) begin
                clr_c    = '0;
                clr_c[i] = 1'b1;
                code_c   = cause_code(i);
            end
        end
    end

endmodule

// File: rtl/exc_sequencer.sv
// Exception/interrupt sequencer: pending capture, priority pick, Exc/ExcAck/ERET handshake.
// Define EXC_ACK_TIMEOUT_EN to add the REQ-state acknowledge watchdog (ACK_TIMEOUT cycles).
module exc_sequencer
    import exc_pkg::*;
#(
    parameter int unsigned NIRQ = 4
`ifdef EXC_ACK_TIMEOUT_EN
    ,
    parameter int unsigned ACK_TIMEOUT = 16
`endif
) (
    input  logic            clk,
    input  logic            reset,
    exc_sequencer_if.slave  bus
);

    localparam int unsigned PW = NIRQ + 1;

    exc_state_t    state, state_nxt;
    logic [PW-1:0] pend_q;
    logic [3:0]    es_q;
    logic          exc_q;
    logic          busy_q;
    logic          eerr_q;
    logic          tmo_q;

    logic          sel_valid_c;
    logic [PW-1:0] sel_clr_c;
    logic [3:0]    sel_code_c;
    logic [PW-1:0] src_c;
    logic          take_c;
    logic          timeout_c;

    // Masked pulses are dropped before they ever reach the pending register.
    assign src_c = {bus.irq & ~bus.irq_mask, bus.invalid_op};

    exc_prio_enc #(.NIRQ(NIRQ)) u_prio (
        .req     (pend_q),
        .valid_c (sel_valid_c),
        .clr_c   (sel_clr_c),
        .code_c  (sel_code_c)
    );

`ifdef EXC_ACK_TIMEOUT_EN
    localparam int unsigned CW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    logic [CW-1:0] wd_q;

    // An acknowledge arriving on the limit cycle still wins.
    assign timeout_c = (state == REQ) && !bus.exc_ack && (wd_q == CW'(ACK_TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_q <= '0;
        end else if (take_c) begin
            wd_q <= '0;
        end else if ((state == REQ) && !bus.exc_ack) begin
            wd_q <= wd_q + CW'(1);
        end
    end
`else
    assign timeout_c = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        take_c    = 1'b0;
        case (state)
            IDLE: begin
                if (sel_valid_c) begin
                    state_nxt = REQ;
                    take_c    = 1'b1;
                end
            end
            REQ: begin
                if (bus.exc_ack) begin
                    state_nxt = HANDLER;
                end else if (timeout_c) begin
                    state_nxt = IDLE;
                end
            end
            HANDLER: begin
                if (bus.eret) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, pending capture and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            pend_q <= '0;
            es_q   <= ES_NONE;
            exc_q  <= 1'b0;
            busy_q <= 1'b0;
            eerr_q <= 1'b0;
            tmo_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            // A new event on the bit being cleared this cycle survives.
            pend_q <= (pend_q & ~(sel_clr_c & {PW{take_c}})) | src_c;
            exc_q  <= (state_nxt == REQ);
            busy_q <= (state_nxt != IDLE);
            eerr_q <= bus.eret && (state != HANDLER);
            tmo_q  <= timeout_c;
            if (take_c) begin
                es_q <= sel_code_c;
            end else if (state_nxt == IDLE) begin
                es_q <= ES_NONE;
            end
        end
    end

    assign bus.exc         = exc_q;
    assign bus.estatus     = es_q;
    assign bus.busy        = busy_q;
    assign bus.pending     = pend_q;
    assign bus.eret_err    = eerr_q;
    assign bus.ack_timeout = tmo_q;

endmodule

// File: tb/tb_exc_sequencer.sv
// Directed bench for exc_sequencer with a cycle-level reference model and per-cycle compare.
module tb_exc_sequencer;
    import exc_pkg::*;

    localparam int unsigned NIRQ        = 4;
    localparam int unsigned ACK_TIMEOUT = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    exc_sequencer_if #(.NIRQ(NIRQ)) bus ();

    exc_sequencer #(.NIRQ(NIRQ)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors    = 0;
    int miscompares = 0;
    bit chk_en     = 1'b0;

    task automatic cmp(input string nm, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: phase 0 = no request, 1 = awaiting ack, 2 = in handler.
    int            m_ph    = 0;
    int            m_cause = 0;
    int            m_wait  = 0;
    logic [NIRQ:0] m_pend  = '0;
    logic          m_eerr  = 1'b0;
    logic          m_tmo   = 1'b0;

    always @(posedge clk or negedge reset) begin : model
        int            ph;
        int            cause;
        int            wt;
        logic [NIRQ:0] pd;
        logic          eerr;
        logic          tmo;
        if (!reset) begin
            m_ph    <= 0;
            m_cause <= 0;
            m_wait  <= 0;
            m_pend  <= '0;
            m_eerr  <= 1'b0;
            m_tmo   <= 1'b0;
        end else begin
            ph    = m_ph;
            cause = m_cause;
            wt    = m_wait;
            pd    = m_pend;
            tmo   = 1'b0;
            eerr  = bus.eret && (m_ph != 2);
            if (ph == 0) begin
                for (int i = 0; i <= int'(NIRQ); i++) begin
                    if (pd[i]) begin
                        cause = i + 1;
                        pd[i] = 1'b0;
                        ph    = 1;
                        wt    = 0;
                        break;
                    end
                end
            end else if (ph == 1) begin
                if (bus.exc_ack) ph = 2;
`ifdef EXC_ACK_TIMEOUT_EN
                else if (wt == int'(ACK_TIMEOUT) - 1) begin
                    ph    = 0;
                    cause = 0;
                    tmo   = 1'b1;
                end
`endif
                else wt = wt + 1;
            end else if (bus.eret) begin
                ph    = 0;
                cause = 0;
            end
            pd = pd | {bus.irq & ~bus.irq_mask, bus.invalid_op};
            m_ph    <= ph;
            m_cause <= cause;
            m_wait  <= wt;
            m_pend  <= pd;
            m_eerr  <= eerr;
            m_tmo   <= tmo;
        end
    end

    // Per-cycle compare on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("m_exc",     int'(bus.exc),         (m_ph == 1) ? 1 : 0);
            cmp("m_busy",    int'(bus.busy),        (m_ph != 0) ? 1 : 0);
            cmp("m_estatus", int'(bus.estatus),     m_cause);
            cmp("m_pending", int'(bus.pending),     int'(m_pend));
            cmp("m_eret_err",int'(bus.eret_err),    int'(m_eerr));
            cmp("m_tmo",     int'(bus.ack_timeout), int'(m_tmo));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_exc(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.exc === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic serve(input int code, input string nm);
        bit ok;
        wait_exc(ok);
        cmp({nm, "_req_seen"}, int'(ok), 1);
        cmp({nm, "_code"}, int'(bus.estatus), code);
        bus.exc_ack = 1'b1;
        tick();
        bus.exc_ack = 1'b0;
        cmp({nm, "_hdl_exc"},  int'(bus.exc), 0);
        cmp({nm, "_hdl_busy"}, int'(bus.busy), 1);
        cmp({nm, "_hdl_code"}, int'(bus.estatus), code);
        bus.eret = 1'b1;
        tick();
        bus.eret = 1'b0;
        cmp({nm, "_eret_busy"}, int'(bus.busy), 0);
        cmp({nm, "_eret_code"}, int'(bus.estatus), 0);
    endtask

    initial begin
        bit ok;
        int n;
        bus.invalid_op = 1'b0;
        bus.irq        = '0;
        bus.irq_mask   = '0;
        bus.eret       = 1'b0;
        bus.exc_ack    = 1'b0;

        // Reset values
        repeat (2) tick();
        cmp("rst_exc",  int'(bus.exc), 0);
        cmp("rst_pend", int'(bus.pending), 0);
        cmp("rst_es",   int'(bus.estatus), 0);
        reset  = 1'b1;
        chk_en = 1'b1;
        tick();

        // Single invalid opcode: pending next cycle, request the one after
        bus.invalid_op = 1'b1;
        tick();
        bus.invalid_op = 1'b0;
        cmp("t1_pend", int'(bus.pending), 1);
        cmp("t1_exc0", int'(bus.exc), 0);
        tick();
        cmp("t1_exc", int'(bus.exc), 1);
        cmp("t1_es",  int'(bus.estatus), 1);
        cmp("t1_pend_clr", int'(bus.pending), 0);
        tick();
        cmp("t1_exc_hold", int'(bus.exc), 1);
        bus.exc_ack = 1'b1;
        tick();
        bus.exc_ack = 1'b0;
        cmp("t1_hdl_exc", int'(bus.exc), 0);
        cmp("t1_hdl_es",  int'(bus.estatus), 1);
        bus.eret = 1'b1;
        tick();
        bus.eret = 1'b0;
        cmp("t1_idle_busy", int'(bus.busy), 0);
        cmp("t1_eret_err",  int'(bus.eret_err), 0);

        // Priority order: invalid op, then irq1 (code 3), then irq2 (code 4)
        bus.irq        = 4'b0110;
        bus.invalid_op = 1'b1;
        tick();
        bus.irq        = '0;
        bus.invalid_op = 1'b0;
        cmp("t2_pend", int'(bus.pending), 5'b01101);
        serve(1, "t2a");
        serve(3, "t2b");
        serve(4, "t2c");
        tick();
        cmp("t2_drained", int'(bus.pending), 0);

        // Masked line never captured
        bus.irq_mask = 4'b0100;
        bus.irq      = 4'b0100;
        tick();
        bus.irq = '0;
        cmp("t3_pend", int'(bus.pending), 0);
        repeat (3) tick();
        cmp("t3_exc", int'(bus.exc), 0);
        bus.irq_mask = '0;

        // ERET while idle
        bus.eret = 1'b1;
        tick();
        bus.eret = 1'b0;
        cmp("t4_eerr",  int'(bus.eret_err), 1);
        cmp("t4_busy",  int'(bus.busy), 0);
        cmp("t4_es",    int'(bus.estatus), 0);
        tick();
        cmp("t4_eerr_pulse", int'(bus.eret_err), 0);

        // IRQ during handler waits until ERET, then requests 2 cycles later
        bus.invalid_op = 1'b1;
        tick();
        bus.invalid_op = 1'b0;
        wait_exc(ok);
        cmp("t5_req_seen", int'(ok), 1);
        bus.exc_ack = 1'b1;
        tick();
        bus.exc_ack = 1'b0;
        bus.irq = 4'b0001;
        tick();
        bus.irq = '0;
        cmp("t5_pend", int'(bus.pending), 5'b00010);
        repeat (2) tick();
        cmp("t5_no_nest", int'(bus.exc), 0);
        bus.eret = 1'b1;
        tick();
        bus.eret = 1'b0;
        cmp("t5_idle_exc", int'(bus.exc), 0);
        tick();
        cmp("t5_rereq", int'(bus.exc), 1);
        cmp("t5_es",    int'(bus.estatus), 2);
        bus.exc_ack = 1'b1;
        tick();
        bus.exc_ack = 1'b0;
        bus.eret = 1'b1;
        tick();
        bus.eret = 1'b0;

        // Ack while idle ignored; ERET in REQ flags error but keeps the request
        bus.exc_ack = 1'b1;
        tick();
        bus.exc_ack = 1'b0;
        cmp("t6_ack_idle", int'(bus.busy), 0);
        bus.invalid_op = 1'b1;
        tick();
        bus.invalid_op = 1'b0;
        tick();
        bus.eret = 1'b1;
        tick();
        bus.eret = 1'b0;
        cmp("t6_eerr", int'(bus.eret_err), 1);
        cmp("t6_exc",  int'(bus.exc), 1);
        bus.exc_ack = 1'b1;
        tick();
        bus.exc_ack = 1'b0;
        bus.eret = 1'b1;
        tick();
        bus.eret = 1'b0;

        // New event on the bit being selected is kept
        bus.invalid_op = 1'b1;
        tick();
        tick();
        bus.invalid_op = 1'b0;
        cmp("t7_kept", int'(bus.pending), 1);
        cmp("t7_exc",  int'(bus.exc), 1);
        bus.exc_ack = 1'b1;
        tick();
        bus.exc_ack = 1'b0;
        bus.eret = 1'b1;
        tick();
        bus.eret = 1'b0;
        serve(1, "t7b");

        // Acknowledge watchdog
        bus.invalid_op = 1'b1;
        tick();
        bus.invalid_op = 1'b0;
        wait_exc(ok);
        cmp("t8_req_seen", int'(ok), 1);
`ifdef EXC_ACK_TIMEOUT_EN
        n = 0;
        while (bus.exc === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        cmp("t8_req_cycles", n, 16);
        cmp("t8_tmo",  int'(bus.ack_timeout), 1);
        cmp("t8_busy", int'(bus.busy), 0);
        cmp("t8_es",   int'(bus.estatus), 0);
        tick();
        cmp("t8_tmo_pulse", int'(bus.ack_timeout), 0);
        cmp("t8_dropped",   int'(bus.pending), 0);
`else
        n = 0;
        repeat (20) begin
            tick();
            n++;
        end
        cmp("t8_still_req", int'(bus.exc), 1);
        cmp("t8_no_tmo",    int'(bus.ack_timeout), 0);
        bus.exc_ack = 1'b1;
        tick();
        bus.exc_ack = 1'b0;
        bus.eret = 1'b1;
        tick();
        bus.eret = 1'b0;
`endif

        // Asynchronous reset in the middle of REQ discards everything
        bus.invalid_op = 1'b1;
        bus.irq        = 4'b0001;
        tick();
        bus.invalid_op = 1'b0;
        bus.irq        = '0;
        wait_exc(ok);
        cmp("t9_req_seen", int'(ok), 1);
        #3;
        reset = 1'b0;
        #1;
        cmp("t9_exc",  int'(bus.exc), 0);
        cmp("t9_es",   int'(bus.estatus), 0);
        cmp("t9_busy", int'(bus.busy), 0);
        cmp("t9_pend", int'(bus.pending), 0);
        tick();
        reset = 1'b1;
        repeat (2) tick();
        cmp("t9_after_pend", int'(bus.pending), 0);
        cmp("t9_after_exc",  int'(bus.exc), 0);

        repeat (2) tick();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
